frame_builder: RTL and testbench
================================

Name: frame_builder

Overview:
Parametrised transmit framer, successor to the fixed SHR/CRC-16 framer.
- Wraps an 8-bit payload stream with a preamble of configurable length, an SFD byte and a 16- or 32-bit reflected CRC FCS.
- Has valid/ready handshakes on both sides.
- Computes the CRC a full byte per cycle.
- Sits between the MAC payload source and the modulator/encoder byte input.

Parameters:
PREAMBLE_LEN, 8, number of preamble bytes, 1..255
PREAMBLE_BYTE, 8'hAA, preamble byte value
SFD_BYTE, 8'hA7, start-of-frame delimiter, sent once after the preamble
CRC_W, 16, FCS width, 16 or 32 only
CRC_POLY, 32'h0000_8408, reflected polynomial in the low CRC_W bits (0xEDB88320 for CRC-32)
CRC_INIT, 32'hFFFF_FFFF, initial register value, low CRC_W bits used
CRC_XOROUT, 32'h0, XORed into the CRC before transmission, low CRC_W bits used
MAX_PAYLOAD, 127, payload byte limit, used only with FRAMING_MAXLEN_EN

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous, active-low reset
s_valid  in  1  payload byte valid
s_ready  out  1  payload byte accepted when s_valid&&s_ready
s_data  in  8  payload byte
s_last  in  1  marks final payload byte
m_valid  out  1  output byte valid
m_ready  in  1  downstream accepts when m_valid&&m_ready
m_data  out  8  output byte
m_last  out  1  marks final FCS byte of a frame
busy  out  1  high in any state other than IDLE
err_trunc  out  1  one-cycle truncation pulse, FRAMING_MAXLEN_EN only, else tied 0

Behaviour:
Reset:
- State IDLE, crc=CRC_INIT, counters 0.
- Outputs m_valid=0, s_ready=0, m_last=0, busy=0, err_trunc=0.
- Reset asserted mid-frame aborts the frame immediately. No FCS is sent and the next frame starts cleanly.

States IDLE -> PREAMBLE -> SFD -> PAYLOAD -> FCS -> IDLE.
- Every transfer ("beat") is m_valid&&m_ready. When m_ready=0, state, counters and crc hold.
- IDLE: m_valid=0, s_ready=0. When s_valid=1, go to PREAMBLE next cycle. The byte is not consumed.
- PREAMBLE: m_valid=1, m_data=PREAMBLE_BYTE. A counter advances per beat. After beat PREAMBLE_LEN, go to SFD.
- SFD: m_valid=1, m_data=SFD_BYTE. One beat, then go to PAYLOAD. crc=CRC_INIT.
- PAYLOAD: zero-latency pass-through.
  - m_valid=s_valid, m_data=s_data, s_ready=m_ready.
  - On each beat, crc=step(crc,s_data). The step processes 8 bits LSB-first: per bit, fb=crc[0]^d[i]; crc=(crc>>1)^(fb?CRC_POLY:0).
  - A beat with s_last=1 goes to FCS.
  - Minimum payload is 1 byte. Empty frames are unsupported.
- FCS:
  - Latch f=crc^CRC_XOROUT on entry.
  - Send CRC_W/8 bytes, LSB byte first (f[7:0], f[15:8], ...). m_valid=1, s_ready=0.
  - m_last=1 on the final FCS byte. That beat returns to IDLE.
  - Back-to-back frames: IDLE costs one bubble cycle between frames.
- s_ready=0 in all states except PAYLOAD.
- m_data=0 whenever m_valid=0.

Optional Feature:
FRAMING_MAXLEN_EN:
- Defined:
  - A payload counter forces FCS after the MAX_PAYLOAD-th accepted byte, even if s_last=0.
  - err_trunc pulses for 1 cycle on that beat.
  - If s_last was not on that byte, the block enters state DROP after the FCS. DROP: s_ready=1, m_valid=0, bytes discarded until the s_last beat, then IDLE.
  - If s_last coincides with byte MAX_PAYLOAD, there is no err_trunc and no DROP.
- Undefined: no counter, no DROP state, err_trunc=0, unlimited payload.

Decomposition:
- Package framing_pkg holds:
  - the state enum (IDLE, PREAMBLE, SFD, PAYLOAD, FCS, DROP);
  - constants CRC16_POLY_REFL=16'h8408 and CRC32_POLY_REFL=32'hEDB88320;
  - a CRC_W legality check.
- Sub-module crc_byte_step: combinational, parametrised by CRC_W/CRC_POLY, inputs crc_in and data, output crc_out. It is reused by the future receive-side checker.

Test Plan:
- Defaults, payload "123456789" (0x31..0x39), m_ready=1 -> 8×0xAA, 0xA7, 9 payload bytes, 0x91, 0x6F. m_last only on 0x6F. 20 beats total.
- CRC_W=32, POLY=0xEDB88320, XOROUT=0xFFFFFFFF, same payload -> FCS 0x26, 0x39, 0xF4, 0xCB.
- Random m_ready stalls (about 50%) during preamble, payload and FCS -> identical byte sequence. No duplicated or lost bytes. s_ready never high outside PAYLOAD.
- Single-byte payload 0x00, then a second frame presented immediately -> both frames correct, one IDLE bubble between them. FCS = CRC of 0x00 from 0xFFFF (0x0F87) sent as 0x87, 0x0F.
- reset_n pulsed low during the 4th payload byte -> all outputs 0 asynchronously. The next frame starts with a full preamble and correct CRC.
- FRAMING_MAXLEN_EN, MAX_PAYLOAD=4, 6-byte input -> 4 bytes forwarded, err_trunc pulse on byte 4, FCS of those 4 bytes, bytes 5-6 dropped, then IDLE. A 4-byte frame with s_last on byte 4 gives no err_trunc.

Source files
------------

// File: rtl/framing_pkg.sv
// Shared types and constants for the transmit framer and future receive checker.
// Holds the frame state enum, the reflected CRC polynomials and a width legality helper.
// No logic; imported by frame_builder and crc_byte_step users.
package framing_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PREAMBLE = 3'd1,
    SFD      = 3'd2,
    PAYLOAD  = 3'd3,
    FCS      = 3'd4,
    DROP     = 3'd5
  } state_t;

  localparam logic [15:0] CRC16_POLY_REFL = 16'h8408;
  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;

  // Only whole-byte FCS widths of 16 or 32 bits are supported.
  function automatic bit crc_w_legal(input int w);
    return (w == 16) || (w == 32);
  endfunction

endpackage

// File: rtl/crc_byte_step.sv
// Purpose: one reflected CRC update over a full data byte, LSB first.
// Ports:   crc_in (CRC_W) current register, data (8) byte, crc_out (CRC_W) next register.
// Latency: purely combinational; no handshake, no backpressure.
module crc_byte_step #(
  parameter int          CRC_W    = 16,
  parameter logic [31:0] CRC_POLY = 32'h0000_8408
) (
  input  logic [CRC_W-1:0] crc_in,
  input  logic [7:0]       data,
  output logic [CRC_W-1:0] crc_out
);

  localparam logic [CRC_W-1:0] POLY = CRC_POLY[CRC_W-1:0];

  always_comb begin
    crc_out = crc_in;
    for (int i = 0; i < 8; i++) begin
      crc_out = (crc_out >> 1) ^ (((crc_out[0] ^ data[i]) != 1'b0) ? POLY : '0);
    end
  end

endmodule

// File: rtl/frame_builder.sv
// Purpose: wraps a byte payload with preamble, SFD and a 16/32-bit reflected CRC FCS.
// Ports:   clk/reset_n; s_valid/s_ready/s_data/s_last payload in; m_valid/m_ready/m_data/m_last
//          framed bytes out; busy (not IDLE); err_trunc (length-limit pulse).
// Latency: payload is zero-latency pass-through; m_ready low freezes state, counters and CRC.
// Option:  FRAMING_MAXLEN_EN enables the MAX_PAYLOAD truncation counter and the DROP state.
module frame_builder
  import framing_pkg::*;
#(
  parameter int          PREAMBLE_LEN  = 8,
  parameter logic [7:0]  PREAMBLE_BYTE = 8'hAA,
  parameter logic [7:0]  SFD_BYTE      = 8'hA7,
  parameter int          CRC_W         = 16,
  parameter logic [31:0] CRC_POLY      = 32'h0000_8408,
  parameter logic [31:0] CRC_INIT      = 32'hFFFF_FFFF,
  parameter logic [31:0] CRC_XOROUT    = 32'h0000_0000,
  parameter int          MAX_PAYLOAD   = 127
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [7:0] s_data,
  input  logic       s_last,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [7:0] m_data,
  output logic       m_last,
  output logic       busy,
  output logic       err_trunc
);

  localparam int NFCS = CRC_W / 8;

  if (!crc_w_legal(CRC_W)) begin : g_bad_crc_w
    $error("frame_builder: CRC_W must be 16 or 32");
  end

  state_t           r_state, w_state_nxt;
  logic [7:0]       r_cnt, w_cnt_nxt;
  logic [CRC_W-1:0] r_crc, w_crc_nxt;
  logic [CRC_W-1:0] r_fcs, w_fcs_nxt;
  logic [CRC_W-1:0] w_crc_step;
  logic             w_end;

  crc_byte_step #(.CRC_W(CRC_W), .CRC_POLY(CRC_POLY)) u_crc_step (
    .crc_in (r_crc),
    .data   (s_data),
    .crc_out(w_crc_step)
  );

`ifdef FRAMING_MAXLEN_EN
  logic [15:0] r_plen, w_plen_nxt;
  logic        r_drop, w_drop_nxt;
  logic        w_limit, w_trunc;
  assign w_limit   = (r_plen == 16'(MAX_PAYLOAD - 1));
  // The length limit ends the payload just like s_last does.
  assign w_end     = s_last || w_limit;
  assign err_trunc = w_trunc;
`else
  assign w_end     = s_last;
  assign err_trunc = 1'b0;
`endif

  assign busy = (r_state != IDLE);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_crc_nxt   = r_crc;
    w_fcs_nxt   = r_fcs;
    m_valid     = 1'b0;
    m_data      = 8'h00;
    m_last      = 1'b0;
    s_ready     = 1'b0;
`ifdef FRAMING_MAXLEN_EN
    w_plen_nxt  = r_plen;
    w_drop_nxt  = r_drop;
    w_trunc     = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        w_cnt_nxt = 8'd0;
        if (s_valid) w_state_nxt = PREAMBLE;
      end
      PREAMBLE: begin
        m_valid = 1'b1;
        m_data  = PREAMBLE_BYTE;
        if (m_ready) begin
          if (r_cnt == 8'(PREAMBLE_LEN - 1)) begin
            w_cnt_nxt   = 8'd0;
            w_state_nxt = SFD;
          end else begin
            w_cnt_nxt = r_cnt + 8'd1;
          end
        end
      end
      SFD: begin
        m_valid = 1'b1;
        m_data  = SFD_BYTE;
        if (m_ready) begin
          w_crc_nxt   = CRC_INIT[CRC_W-1:0];
          w_state_nxt = PAYLOAD;
`ifdef FRAMING_MAXLEN_EN
          w_plen_nxt  = 16'd0;
          w_drop_nxt  = 1'b0;
`endif
        end
      end
      PAYLOAD: begin
        m_valid = s_valid;
        m_data  = s_valid ? s_data : 8'h00;
        s_ready = m_ready;
        if (s_valid && m_ready) begin
          w_crc_nxt = w_crc_step;
`ifdef FRAMING_MAXLEN_EN
          w_plen_nxt = r_plen + 16'd1;
          w_trunc    = w_limit && !s_last;
          w_drop_nxt = w_limit && !s_last;
`endif
          if (w_end) begin
            // FCS value is latched here so the FCS state only shifts bytes out.
            w_fcs_nxt   = w_crc_step ^ CRC_XOROUT[CRC_W-1:0];
            w_cnt_nxt   = 8'd0;
            w_state_nxt = FCS;
          end
        end
      end
      FCS: begin
        m_valid = 1'b1;
        m_data  = r_fcs[7:0];
        m_last  = (r_cnt == 8'(NFCS - 1));
        if (m_ready) begin
          w_fcs_nxt = r_fcs >> 8;
          w_cnt_nxt = r_cnt + 8'd1;
          if (m_last) begin
            w_cnt_nxt   = 8'd0;
            w_state_nxt = IDLE;
`ifdef FRAMING_MAXLEN_EN
            if (r_drop) w_state_nxt = DROP;
`endif
          end
        end
      end
`ifdef FRAMING_MAXLEN_EN
      DROP: begin
        // Swallow the rest of an over-long payload without emitting anything.
        s_ready = 1'b1;
        if (s_valid && s_last) w_state_nxt = IDLE;
      end
`endif
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= 8'd0;
      r_crc   <= CRC_INIT[CRC_W-1:0];
      r_fcs   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_crc   <= w_crc_nxt;
      r_fcs   <= w_fcs_nxt;
    end
  end

`ifdef FRAMING_MAXLEN_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_plen <= 16'd0;
      r_drop <= 1'b0;
    end else begin
      r_plen <= w_plen_nxt;
      r_drop <= w_drop_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_frame_builder.sv
// Purpose: self-checking bench for frame_builder across three parameter sets.
// Latency: frame-level scoreboard; expected bytes come from hand tables and a CRC model.
// Backpressure: random m_ready stalls and s_valid gaps are applied on chosen frames.
module tb_frame_builder;

  localparam int ND = 3;
`ifdef FRAMING_MAXLEN_EN
  localparam bit MAXLEN = 1'b1;
`else
  localparam bit MAXLEN = 1'b0;
`endif

  typedef logic [7:0] bq_t[$];

  typedef struct {
    int         dut;
    int         len;
    logic [7:0] pl[9];
    int         nfcs;
    logic [7:0] fcs[4];
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       s_valid[ND], s_ready[ND], s_last[ND], m_valid[ND], m_ready[ND];
  logic       m_last[ND], busy[ND], err_trunc[ND];
  logic [7:0] s_data[ND], m_data[ND];

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  frame_builder u_dut0 (
    .clk(clk), .reset_n(reset_n), .s_valid(s_valid[0]), .s_ready(s_ready[0]), .s_data(s_data[0]),
    .s_last(s_last[0]), .m_valid(m_valid[0]), .m_ready(m_ready[0]), .m_data(m_data[0]),
    .m_last(m_last[0]), .busy(busy[0]), .err_trunc(err_trunc[0]));

  frame_builder #(.CRC_W(32), .CRC_POLY(32'hEDB88320), .CRC_XOROUT(32'hFFFF_FFFF)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .s_valid(s_valid[1]), .s_ready(s_ready[1]), .s_data(s_data[1]),
    .s_last(s_last[1]), .m_valid(m_valid[1]), .m_ready(m_ready[1]), .m_data(m_data[1]),
    .m_last(m_last[1]), .busy(busy[1]), .err_trunc(err_trunc[1]));

  frame_builder #(.PREAMBLE_LEN(2), .PREAMBLE_BYTE(8'h55), .SFD_BYTE(8'hD5), .MAX_PAYLOAD(4)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .s_valid(s_valid[2]), .s_ready(s_ready[2]), .s_data(s_data[2]),
    .s_last(s_last[2]), .m_valid(m_valid[2]), .m_ready(m_ready[2]), .m_data(m_data[2]),
    .m_last(m_last[2]), .busy(busy[2]), .err_trunc(err_trunc[2]));

  function automatic int pre_len(input int d);   return (d == 2) ? 2 : 8;           endfunction
  function automatic logic [7:0] pre_b(input int d); return (d == 2) ? 8'h55 : 8'hAA; endfunction
  function automatic logic [7:0] sfd_b(input int d); return (d == 2) ? 8'hD5 : 8'hA7; endfunction
  function automatic int nfcs(input int d);      return (d == 1) ? 4 : 2;           endfunction
  function automatic int maxp(input int d);      return (d == 2) ? 4 : 127;         endfunction
  function automatic int nfwd(input int d, input int len);
    return (MAXLEN && len > maxp(d)) ? maxp(d) : len;
  endfunction

  // Bit-serial reflected CRC over the first n bytes, straight from the polynomial definition.
  function automatic logic [31:0] fcs_model(input int d, input bq_t pl, input int n);
    logic [31:0] poly, c, xo, mask;
    if (d == 1) begin
      poly = 32'hEDB88320; c = 32'hFFFF_FFFF; xo = 32'hFFFF_FFFF; mask = 32'hFFFF_FFFF;
    end else begin
      poly = 32'h8408; c = 32'hFFFF; xo = 32'h0; mask = 32'hFFFF;
    end
    for (int i = 0; i < n; i++)
      for (int b = 0; b < 8; b++)
        if ((c[0] ^ pl[i][b]) != 1'b0) c = (c >> 1) ^ poly;
        else c = c >> 1;
    return (c ^ xo) & mask;
  endfunction

  function automatic bq_t build_frame(input int d, input bq_t pl, input int nf, input bq_t fcs);
    bq_t e;
    e = {};
    for (int i = 0; i < pre_len(d); i++) e.push_back(pre_b(d));
    e.push_back(sfd_b(d));
    for (int i = 0; i < nf; i++) e.push_back(pl[i]);
    foreach (fcs[i]) e.push_back(fcs[i]);
    return e;
  endfunction

  function automatic bq_t model_frame(input int d, input bq_t pl);
    bq_t f;
    logic [31:0] v;
    int nf;
    nf = nfwd(d, pl.size());
    v = fcs_model(d, pl, nf);
    f = {};
    for (int k = 0; k < nfcs(d); k++) f.push_back(8'(v >> (8 * k)));
    return build_frame(d, pl, nf, f);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Drives one frame into DUT d and records every output beat. abort_at >= 0 pulses
  // reset while payload byte abort_at is presented, checks outputs, and returns early.
  task automatic run_frame(input int d, input bq_t pl, input bit stall, input int abort_at,
                           output bq_t got, output int lastpos, output int bubble,
                           output int bad, output int trunc_n, output bit aborted);
    int idx, nb, cyc, len, pre, nf;
    bit seen_last;
    idx = 0; nb = 0; cyc = 0; len = pl.size(); pre = pre_len(d); nf = nfwd(d, len);
    seen_last = 0; got = {}; lastpos = -1; bubble = 0; bad = 0; trunc_n = 0; aborted = 0;
    while (!(seen_last && idx >= len) && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      s_valid[d] = (idx < len) && (!stall || $urandom_range(0, 3) != 0);
      s_data[d]  = (idx < len) ? pl[idx] : 8'hEE;
      s_last[d]  = (idx == len - 1);
      m_ready[d] = !stall || ($urandom_range(0, 1) == 1);
      #1;
      if (abort_at >= 0 && idx == abort_at && s_valid[d] && nb > pre) begin
        reset_n = 1'b0;
        #1;
        check("abort_m_valid", 32'(m_valid[d]), 0);
        check("abort_s_ready", 32'(s_ready[d]), 0);
        check("abort_m_last", 32'(m_last[d]), 0);
        check("abort_busy", 32'(busy[d]), 0);
        check("abort_m_data", 32'(m_data[d]), 0);
        reset_n = 1'b1;
        s_valid[d] = 1'b0;
        s_last[d] = 1'b0;
        aborted = 1;
        break;
      end
      if (err_trunc[d]) trunc_n++;
      if (!m_valid[d] && m_data[d] != 8'h00) bad++;
      if (s_ready[d] && !(nb >= pre + 1 && (nb < pre + 1 + nf || seen_last))) bad++;
      if (m_valid[d] && m_ready[d]) begin
        got.push_back(m_data[d]);
        if (m_last[d]) begin lastpos = nb; seen_last = 1; end
        nb++;
      end else if (nb == 0) begin
        bubble++;
      end
      if (s_valid[d] && s_ready[d]) idx++;
    end
    if (!aborted) begin
      check("frame_timeout", 32'(cyc < 3000), 1);
      @(posedge clk);
      #1;
      s_valid[d] = 1'b0;
      s_last[d]  = 1'b0;
      check("busy_after_frame", 32'(busy[d]), 0);
    end
  endtask

  task automatic verify(input bq_t got, input bq_t exp, input int lastpos, input int bad,
                        input int trunc_n, input int exp_trunc);
    int n;
    check("frame_len", 32'(got.size()), 32'(exp.size()));
    n = (got.size() < exp.size()) ? got.size() : exp.size();
    for (int i = 0; i < n; i++) check($sformatf("byte[%0d]", i), 32'(got[i]), 32'(exp[i]));
    check("m_last_pos", 32'(lastpos), 32'(exp.size() - 1));
    check("s_ready_m_data_rules", 32'(bad), 0);
    check("err_trunc_pulses", 32'(trunc_n), 32'(exp_trunc));
  endtask

  initial begin
    vec_t vecs[3];
    bq_t pl, pl2, got, exp, fcs;
    int lastpos, bubble, bad, trunc_n, len, d;
    bit aborted;

    for (int i = 0; i < ND; i++) begin
      s_valid[i] = 0; s_last[i] = 0; s_data[i] = 8'h00; m_ready[i] = 1;
    end

    vecs[0] = '{dut: 0, len: 9, pl: '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39},
                nfcs: 2, fcs: '{8'h91, 8'h6F, 8'h00, 8'h00}};
    vecs[1] = '{dut: 1, len: 9, pl: '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39},
                nfcs: 4, fcs: '{8'h26, 8'h39, 8'hF4, 8'hCB}};
    vecs[2] = '{dut: 0, len: 1, pl: '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                nfcs: 2, fcs: '{8'h87, 8'h0F, 8'h00, 8'h00}};

    #1;
    for (int i = 0; i < ND; i++) begin
      check($sformatf("reset_m_valid%0d", i), 32'(m_valid[i]), 0);
      check($sformatf("reset_s_ready%0d", i), 32'(s_ready[i]), 0);
      check($sformatf("reset_m_last%0d", i), 32'(m_last[i]), 0);
      check($sformatf("reset_busy%0d", i), 32'(busy[i]), 0);
      check($sformatf("reset_err_trunc%0d", i), 32'(err_trunc[i]), 0);
    end
    #20;
    reset_n = 1'b1;

    // Hand-computed vectors; the unstalled ones also fix the start-up bubble at one cycle.
    for (int v = 0; v < 3; v++) begin
      pl = {}; fcs = {};
      for (int i = 0; i < vecs[v].len; i++) pl.push_back(vecs[v].pl[i]);
      for (int i = 0; i < vecs[v].nfcs; i++) fcs.push_back(vecs[v].fcs[i]);
      exp = build_frame(vecs[v].dut, pl, pl.size(), fcs);
      run_frame(vecs[v].dut, pl, 0, -1, got, lastpos, bubble, bad, trunc_n, aborted);
      verify(got, exp, lastpos, bad, trunc_n, 0);
      check("start_bubble", 32'(bubble), 1);
    end

    // Single 0x00 frame followed immediately by a second frame: exactly one idle bubble.
    pl = {8'h00};
    pl2 = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    run_frame(0, pl, 0, -1, got, lastpos, bubble, bad, trunc_n, aborted);
    verify(got, build_frame(0, pl, 1, '{8'h87, 8'h0F}), lastpos, bad, trunc_n, 0);
    run_frame(0, pl2, 0, -1, got, lastpos, bubble, bad, trunc_n, aborted);
    verify(got, build_frame(0, pl2, 9, '{8'h91, 8'h6F}), lastpos, bad, trunc_n, 0);
    check("b2b_bubble", 32'(bubble), 1);

    // Same known payload under random stalls must yield the identical byte sequence.
    run_frame(0, pl2, 1, -1, got, lastpos, bubble, bad, trunc_n, aborted);
    verify(got, build_frame(0, pl2, 9, '{8'h91, 8'h6F}), lastpos, bad, trunc_n, 0);
    run_frame(1, pl2, 1, -1, got, lastpos, bubble, bad, trunc_n, aborted);
    verify(got, build_frame(1, pl2, 9, '{8'h26, 8'h39, 8'hF4, 8'hCB}), lastpos, bad, trunc_n, 0);

    // Reset during the 4th payload byte, then a clean frame with full preamble and CRC.
    pl = {};
    for (int i = 0; i < 8; i++) pl.push_back(8'($urandom));
    run_frame(0, pl, 0, 3, got, lastpos, bubble, bad, trunc_n, aborted);
    check("abort_taken", 32'(aborted), 1);
    check("abort_no_fcs", 32'(lastpos), 32'hFFFF_FFFF);
    run_frame(0, pl, 0, -1, got, lastpos, bubble, bad, trunc_n, aborted);
    verify(got, model_frame(0, pl), lastpos, bad, trunc_n, 0);

    // Length limit on the MAX_PAYLOAD=4 instance: 6 bytes (truncated when enabled), then exactly 4.
    pl = {8'h10, 8'h21, 8'h32, 8'h43, 8'h54, 8'h65};
    run_frame(2, pl, 0, -1, got, lastpos, bubble, bad, trunc_n, aborted);
    verify(got, model_frame(2, pl), lastpos, bad, trunc_n, MAXLEN ? 1 : 0);
    pl = {8'h10, 8'h21, 8'h32, 8'h43};
    run_frame(2, pl, 0, -1, got, lastpos, bubble, bad, trunc_n, aborted);
    verify(got, model_frame(2, pl), lastpos, bad, trunc_n, 0);

    // Randomised frames with random stalls against the reference model.
    for (int r = 0; r < 15; r++) begin
      d = $urandom_range(0, ND - 1);
      len = (d == 2) ? $urandom_range(1, 7) : $urandom_range(1, 20);
      pl = {};
      for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
      run_frame(d, pl, 1, -1, got, lastpos, bubble, bad, trunc_n, aborted);
      verify(got, model_frame(d, pl), lastpos, bad, trunc_n, (MAXLEN && len > maxp(d)) ? 1 : 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
